// File: rtl/vga_timing.sv
// 640x480@60 raster timing: free-running x/y counters plus sync/blank
// strobes delayed so they line up with colour computed from x/y.
module vga_timing #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       hs_n,
  output logic       vs_n,
  output logic       blank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // {blank, hs_n, vs_n} with all strobes inactive
  localparam logic [2:0] IDLE = 3'b011;

  logic       line_end;
  logic       raw_blank;
  logic       raw_hs_n;
  logic       raw_vs_n;
  logic [2:0] pipe [PIPE_DELAY];

  assign line_end = (x == H_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
    end else if (line_end) begin
      x <= '0;
    end else begin
      x <= x + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y <= '0;
    end else if (line_end) begin
      y <= (y == V_LAST) ? '0 : y + 10'd1;
    end
  end

  always_comb begin
    raw_blank = (x < H_VIS) && (y < V_VIS);
    raw_hs_n  = !((x >= HS_ON) && (x < HS_OFF));
    raw_vs_n  = !((y >= VS_ON) && (y < VS_OFF));
  end

  assign frame_start = (x == '0) && (y == '0);

  // Stage 0 takes the raw decode; the last stage feeds the mixer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe[i] <= IDLE;
      end
    end else begin
      pipe[0] <= {raw_blank, raw_hs_n, raw_vs_n};
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign {blank, hs_n, vs_n} = pipe[PIPE_DELAY-1];

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: three shrunken rasters (delays 2/1/5)
// and one full 640x480 raster checked cycle by cycle against a model.
module tb_vga_timing;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] xo [N];
  logic [9:0] yo [N];
  logic       fso [N];
  logic       hso [N];
  logic       vso [N];
  logic       blo [N];

  int c_hv [N] = '{16, 16, 16, 640};
  int c_hf [N] = '{2, 2, 2, 16};
  int c_hs [N] = '{3, 3, 3, 96};
  int c_hb [N] = '{2, 2, 2, 48};
  int c_vv [N] = '{6, 6, 6, 480};
  int c_vf [N] = '{1, 1, 1, 10};
  int c_vs [N] = '{2, 2, 2, 2};
  int c_vb [N] = '{1, 1, 1, 33};
  int c_d  [N] = '{2, 1, 5, 2};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int         mx [N];
  int         my [N];
  logic [2:0] sq [N][$];

  logic p_hs [N], p_vs [N], p_bl [N];
  bit   s_hs [N], s_vs [N], s_bl [N], s_fs [N];
  int   r_hs [N], r_vs [N], r_bl [N];
  int   t_hx [N], t_fs [N];

  always #5 clk = ~clk;

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(2)
  ) u0 (
    .clk(clk), .reset(reset), .x(xo[0]), .y(yo[0]),
    .frame_start(fso[0]), .hs_n(hso[0]), .vs_n(vso[0]),
    .blank(blo[0])
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(1)
  ) u1 (
    .clk(clk), .reset(reset), .x(xo[1]), .y(yo[1]),
    .frame_start(fso[1]), .hs_n(hso[1]), .vs_n(vso[1]),
    .blank(blo[1])
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(5)
  ) u2 (
    .clk(clk), .reset(reset), .x(xo[2]), .y(yo[2]),
    .frame_start(fso[2]), .hs_n(hso[2]), .vs_n(vso[2]),
    .blank(blo[2])
  );

  vga_timing u3 (
    .clk(clk), .reset(reset), .x(xo[3]), .y(yo[3]),
    .frame_start(fso[3]), .hs_n(hso[3]), .vs_n(vso[3]),
    .blank(blo[3])
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic string tg(string s, int i);
    return $sformatf("%s%0d", s, i);
  endfunction

  function automatic int ht(int i);
    return c_hv[i] + c_hf[i] + c_hs[i] + c_hb[i];
  endfunction

  function automatic int vt(int i);
    return c_vv[i] + c_vf[i] + c_vs[i] + c_vb[i];
  endfunction

  function automatic logic [2:0] raw(int i, int x, int y);
    logic bl, hs, vs;
    bl = (x < c_hv[i]) && (y < c_vv[i]);
    hs = !(x >= c_hv[i] + c_hf[i] &&
           x <  c_hv[i] + c_hf[i] + c_hs[i]);
    vs = !(y >= c_vv[i] + c_vf[i] &&
           y <  c_vv[i] + c_vf[i] + c_vs[i]);
    return {bl, hs, vs};
  endfunction

  task automatic advance();
    for (int i = 0; i < N; i++) begin
      mx[i]++;
      if (mx[i] == ht(i)) begin
        mx[i] = 0;
        my[i]++;
        if (my[i] == vt(i)) my[i] = 0;
      end
    end
  endtask

  task automatic sample();
    for (int i = 0; i < N; i++) begin
      logic [2:0] o, e;
      o = {blo[i], hso[i], vso[i]};
      if (reset) begin
        mx[i] = 0;
        my[i] = 0;
        sq[i].delete();
        repeat (c_d[i]) sq[i].push_back(3'b011);
        s_hs[i] = 0; s_vs[i] = 0; s_bl[i] = 0; s_fs[i] = 0;
      end
      chk(tg("x", i), 32'(xo[i]), 32'(mx[i]));
      chk(tg("y", i), 32'(yo[i]), 32'(my[i]));
      chk(tg("fs", i), 32'(fso[i]), 32'(mx[i] == 0 && my[i] == 0));
      e = sq[i].pop_front();
      chk(tg("bl_hs_vs", i), 32'(o), 32'(e));
      sq[i].push_back(raw(i, mx[i], my[i]));
      if (!reset) begin
        if (mx[i] == c_hv[i] + c_hf[i]) t_hx[i] = cyc;
        if (!o[1]) begin
          if (p_hs[i]) begin
            s_hs[i] = 1;
            r_hs[i] = 1;
            chk(tg("hs_delay", i), 32'(cyc - t_hx[i]), 32'(c_d[i]));
          end else begin
            r_hs[i]++;
          end
        end else if (!p_hs[i] && s_hs[i]) begin
          chk(tg("hs_width", i), 32'(r_hs[i]), 32'(c_hs[i]));
        end
        if (!o[0]) begin
          if (p_vs[i]) begin
            s_vs[i] = 1;
            r_vs[i] = 1;
          end else begin
            r_vs[i]++;
          end
        end else if (!p_vs[i] && s_vs[i]) begin
          chk(tg("vs_width", i), 32'(r_vs[i]), 32'(c_vs[i] * ht(i)));
        end
        if (o[2]) begin
          if (!p_bl[i]) begin
            s_bl[i] = 1;
            r_bl[i] = 1;
          end else begin
            r_bl[i]++;
          end
        end else if (p_bl[i] && s_bl[i]) begin
          chk(tg("bl_width", i), 32'(r_bl[i]), 32'(c_hv[i]));
        end
        if (fso[i]) begin
          if (s_fs[i])
            chk(tg("frame_per", i), 32'(cyc - t_fs[i]), 32'(ht(i) * vt(i)));
          s_fs[i] = 1;
          t_fs[i] = cyc;
        end
      end
      p_bl[i] = o[2];
      p_hs[i] = o[1];
      p_vs[i] = o[0];
    end
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) advance();
    @(negedge clk);
    sample();
  endtask

  initial begin
    bit hit;
    reset = 1'b1;
    @(negedge clk);
    sample();
    repeat (2) cycle();
    reset = 1'b0;
    repeat (1800) cycle();

    hit = 0;
    for (int k = 0; k < 300 && !hit; k++) begin
      cycle();
      hit = (mx[0] == 10 && my[0] == 4);
    end
    chk("seek_mid_frame", 32'(hit), 32'd1);

    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk(tg("async_x", i), 32'(xo[i]), 32'd0);
      chk(tg("async_y", i), 32'(yo[i]), 32'd0);
      chk(tg("async_fs", i), 32'(fso[i]), 32'd1);
      chk(tg("async_out", i),
          32'({blo[i], hso[i], vso[i]}), 32'(3'b011));
    end
    @(negedge clk);
    sample();
    repeat (2) cycle();
    reset = 1'b0;
    repeat (400) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640×480@60 VGA raster timing from the 25 MHz pixel clock. Provides the pixel coordinates used by the background and sprite generators. Also produces the sync strobes and the `blank` signal that the mixer uses to gate colour. Sync and `blank` are delayed by a configurable pipeline depth, so they reach the mixer in step with colour data computed from `x`/`y`.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `PIPE_DELAY`, 2, clocks of delay applied to `hs_n`/`vs_n`/`blank` relative to `x`/`y`; legal range 1..8
- `clk`  in  1  pixel clock, 25 MHz; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `x`  out  10  current horizontal count, 0..H_TOTAL-1
- `y`  out  10  current vertical count, 0..V_TOTAL-1
- `frame_start`  out  1  high for one clock when `x`==0 and `y`==0
- `hs_n`  out  1  horizontal sync, active low, delayed PIPE_DELAY clocks
- `vs_n`  out  1  vertical sync, active low, delayed PIPE_DELAY clocks
- `blank`  out  1  **high = visible region**, low = blanking; delayed PIPE_DELAY clocks. Polarity matches the mixer's `blank` input.

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Horizontal counter: 10-bit register. Increments every clock. At H_TOTAL-1 it wraps to 0 on the next clock.
- Vertical counter: 10-bit register. Increments only on the clock where the horizontal counter wraps. At V_TOTAL-1, that same wrap takes it to 0.
- `x`/`y` are the counter registers themselves, with no added delay.
- Raw decodes are combinational from the counters:
  - raw_blank = (x < H_VISIBLE) && (y < V_VISIBLE)
  - raw_hs_n = !(x ≥ H_VISIBLE+H_FRONT && x < H_VISIBLE+H_FRONT+H_SYNC), i.e. low for x in 656..751
  - raw_vs_n = !(y ≥ V_VISIBLE+V_FRONT && y < V_VISIBLE+V_FRONT+V_SYNC), i.e. low for lines 490..491, for all x on those lines
- Delay line: raw_blank/raw_hs_n/raw_vs_n feed a PIPE_DELAY-stage shift register. The last stage drives `blank`/`hs_n`/`vs_n`, so all outputs are registered.
- `frame_start` = (x==0 && y==0). It is combinational from the counter registers and not delayed.
- No enable input. The raster runs freely whenever out of reset.

## Timing
- Reset values (asynchronous, held while `reset`=1): `x`=0, `y`=0, every delay stage loads the inactive value, so `hs_n`=1, `vs_n`=1, `blank`=0. `frame_start`=1, because it decodes x=y=0.
- First clock edge after reset release: `x` becomes 1. `frame_start` is high for exactly the first post-reset cycle.
- Latency: a raw decode for counter value (h,v) appears on `blank`/`hs_n`/`vs_n` exactly PIPE_DELAY rising edges later.
- After reset release, the delay line shows inactive values for the first PIPE_DELAY clocks. At that point `blank` rises, reflecting pixel (0,0).
- Line period: 800 clocks. Frame period: 420 000 clocks between consecutive `frame_start` pulses.
- Per line: `blank` is high for 640 consecutive clocks on visible lines and 0 clocks on lines 480..524. `hs_n` is low for 96 consecutive clocks on every line.
- vsync: `vs_n` is low for 1600 consecutive clocks (2 lines). Its edges are aligned to the horizontal wrap, shifted by PIPE_DELAY.
- Wrap boundary: at (799,524), the next clock gives (0,0) and `frame_start`=1.
- Reset mid-frame: counters and the delay line clear immediately, without waiting for a clock. The raster restarts at (0,0). Any partial line or frame is discarded.

## Test plan
- Reset with PIPE_DELAY=2, then release: during reset x=0, y=0, hs_n=1, vs_n=1, blank=0, frame_start=1. On the 1st edge after release x=1 and frame_start=0. `blank` goes to 1 after the 2nd edge.
- Horizontal sweep on line y=0: x counts 0..799, then returns to 0 and y becomes 1. `hs_n` is low exactly while the delayed x is 656..751 (96 clocks). `blank` is high for 640 clocks.
- Vertical: count lines with `vs_n` low. Result is 2 (lines 490, 491), 1600 clocks total. `blank` stays 0 for all of lines 480..524.
- Frame period: measure the interval between two `frame_start` pulses. Result is 420 000 clocks, with exactly one pulse per frame.
- Reset asserted at (x=300,y=200) for 3 clocks: outputs return to reset values within the same cycle, without waiting for a clock edge. After release, timing matches the first scenario.
- PIPE_DELAY=1 and PIPE_DELAY=5: the `hs_n` falling edge occurs 1 and 5 clocks, respectively, after x==656.
